// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory read arbiter.
//   arb_state_e   : transaction sequencer states (IDLE -> ADDR -> DATA -> IDLE)
//   RESP_OKAY     : RRESP encoding of a clean beat
//   PROT_DEFAULT  : default constant driven on ARPROT
//   wrap_inc()    : modular index increment, used by the round-robin search
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [2:0] PROT_DEFAULT = 3'b111;

  // (base + off) mod n, for walking requester indices in a ring
  function automatic int unsigned wrap_inc(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory read arbiter.
// Build option: MEM_ARB_RR_EN defined -> round-robin search starting at ptr_i;
//               undefined              -> fixed priority, lowest index wins (ptr_i ignored).
// Ports:
//   req_i      : per-requester request vector
//   ptr_i      : round-robin start index
//   win_oh_c   : one-hot winner (zero when no request)
//   win_idx_c  : binary winner index
//   win_any_c  : at least one request present
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] win_oh_c,
  output logic [IDX_W-1:0] win_idx_c,
  output logic             win_any_c
);

  logic [IDX_W-1:0] cand;

`ifdef MEM_ARB_RR_EN
  // First requester found walking the ring from ptr_i
  always_comb begin
    win_oh_c  = '0;
    win_idx_c = '0;
    win_any_c = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IDX_W'(wrap_inc(32'(ptr_i), i, N_REQ));
      if (!win_any_c && req_i[cand]) begin
        win_oh_c[cand] = 1'b1;
        win_idx_c      = cand;
        win_any_c      = 1'b1;
      end
    end
  end
`else
  // Lowest requesting index wins
  always_comb begin
    win_oh_c  = '0;
    win_idx_c = '0;
    win_any_c = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IDX_W'(i);
      if (!win_any_c && req_i[cand]) begin
        win_oh_c[cand] = 1'b1;
        win_idx_c      = cand;
        win_any_c      = 1'b1;
      end
    end
  end

  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
`endif

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one AXI-style read channel (AR/R) between N_REQ requesters
// (0 = LSU load port, 1 = IFU fetch port), one transaction at a time:
// grant -> AR handshake -> R beats until RLAST -> one-cycle response pulse.
// Build option: MEM_ARB_RR_EN selects round-robin arbitration; default is
// fixed priority with the LSU (index 0) winning.
// Ports:
//   ACLK, ARESETn        : clock, asynchronous active-low reset
//   req_valid, req_addr  : per-requester request and address (slice i = [i*ADDR_W +: ADDR_W])
//   rsp_valid            : one-cycle pulse on the granted requester's bit
//   rsp_data, rsp_err    : last-beat data and OR of bad RRESP over the burst (held)
//   busy                 : transaction in flight
//   ARVALID/ARREADY/ARADDR/ARPROT : read address channel
//   RVALID/RREADY/RLAST/RDATA/RRESP : read data channel
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 64,
  parameter logic [2:0]  AR_PROT = PROT_DEFAULT
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  output logic [ADDR_W-1:0]       ARADDR,
  output logic [2:0]              ARPROT,
  input  logic                    RVALID,
  output logic                    RREADY,
  input  logic                    RLAST,
  input  logic [DATA_W-1:0]       RDATA,
  input  logic [1:0]              RRESP
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e          state_q,     state_d;
  logic [N_REQ-1:0]    grant_q,     grant_d;
  logic [ADDR_W-1:0]   araddr_q,    araddr_d;
  logic                arvalid_q,   arvalid_d;
  logic                rready_q,    rready_d;
  logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q,  rsp_data_d;
  logic                rsp_err_q,   rsp_err_d;
  logic                err_acc_q,   err_acc_d;
  logic                busy_q,      busy_d;

  logic [N_REQ-1:0]    win_oh;
  logic [IDX_W-1:0]    win_idx;
  logic                win_any;
  logic [IDX_W-1:0]    pick_ptr;
  logic [ADDR_W-1:0]   addr_arr [N_REQ];
  logic                beat_err;

`ifdef MEM_ARB_RR_EN
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  assign pick_ptr = rr_ptr_q;
`else
  assign pick_ptr = '0;
`endif

  // Unpack the flat address bus into one entry per requester
  for (genvar g = 0; g < N_REQ; g++) begin : g_addr
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
  end

  mem_arb_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i     (req_valid),
    .ptr_i     (pick_ptr),
    .win_oh_c  (win_oh),
    .win_idx_c (win_idx),
    .win_any_c (win_any)
  );

  assign beat_err = (RRESP != RESP_OKAY);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    err_acc_d   = err_acc_q;
`ifdef MEM_ARB_RR_EN
    rr_ptr_d    = rr_ptr_q;
`endif

    case (state_q)
      IDLE: begin
        if (win_any) begin
          // Address is captured here; later req_addr changes are ignored
          grant_d   = win_oh;
          araddr_d  = addr_arr[win_idx];
          arvalid_d = 1'b1;
          err_acc_d = 1'b0;
          state_d   = ADDR;
`ifdef MEM_ARB_RR_EN
          rr_ptr_d  = IDX_W'(wrap_inc(32'(win_idx), 32'd1, N_REQ));
`endif
        end
      end

      ADDR: begin
        if (arvalid_q && ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = DATA;
        end
      end

      DATA: begin
        if (RVALID) begin
          err_acc_d = err_acc_q | beat_err;
          // Non-last beats only contribute to the error flag
          if (RLAST) begin
            rsp_data_d  = RDATA;
            rsp_err_d   = err_acc_q | beat_err;
            rsp_valid_d = grant_q;
            rready_d    = 1'b0;
            state_d     = IDLE;
          end
        end
      end

      default: begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        state_d   = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      err_acc_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      err_acc_q   <= err_acc_d;
      busy_q      <= busy_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Round-robin pointer, advanced past the winner at each grant
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;
  assign ARVALID   = arvalid_q;
  assign ARADDR    = araddr_q;
  assign ARPROT    = AR_PROT;
  assign RREADY    = rready_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: reset, single read latency, contention,
// backpressure, error burst, reset mid-transaction, requester withdrawal.
module tb_mem_read_arbiter;

  localparam int unsigned N_REQ  = 2;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;

  logic                    ACLK;
  logic                    ARESETn;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_err;
  logic                    busy;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [ADDR_W-1:0]       ARADDR;
  logic [2:0]              ARPROT;
  logic                    RVALID;
  logic                    RREADY;
  logic                    RLAST;
  logic [DATA_W-1:0]       RDATA;
  logic [1:0]              RRESP;

  int n_checks = 0;
  int n_fail   = 0;

  mem_read_arbiter dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .ARVALID   (ARVALID),
    .ARREADY   (ARREADY),
    .ARADDR    (ARADDR),
    .ARPROT    (ARPROT),
    .RVALID    (RVALID),
    .RREADY    (RREADY),
    .RLAST     (RLAST),
    .RDATA     (RDATA),
    .RRESP     (RRESP)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0; req_valid = '0; req_addr = '0; ARREADY = 1'b0;
    RVALID = 1'b0; RLAST = 1'b0; RDATA = '0; RRESP = 2'b00;
    tick(); tick();
    n_checks++;
    if ({ARVALID, RREADY, busy, rsp_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got arv/rr/busy/err=%b want 0000", {ARVALID, RREADY, busy, rsp_err});
    end
    n_checks++;
    if (ARADDR !== 32'h0 || rsp_data !== 64'h0 || rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL reset_data: got araddr=%h data=%h rspv=%b want zeros", ARADDR, rsp_data, rsp_valid);
    end
    n_checks++;
    if (ARPROT !== 3'b111) begin
      n_fail++; $display("FAIL arprot: got %b want 111", ARPROT);
    end
    ARESETn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    ARREADY = 1'b1;
    req_addr[ADDR_W +: ADDR_W] = 32'h8000_0000;
    req_valid = 2'b10;
    tick();
    n_checks++;
    if ({ARVALID, busy} !== 2'b11 || ARADDR !== 32'h8000_0000) begin
      n_fail++; $display("FAIL single_ar: got arv=%b busy=%b addr=%h want 1 1 80000000", ARVALID, busy, ARADDR);
    end
    RVALID = 1'b1; RLAST = 1'b1; RDATA = 64'h1122_3344_5566_7788; RRESP = 2'b00;
    tick();
    n_checks++;
    if ({ARVALID, RREADY} !== 2'b01 || rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL single_hs: got arv=%b rready=%b rspv=%b want 0 1 00", ARVALID, RREADY, rsp_valid);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 2'b10 || rsp_data !== 64'h1122_3344_5566_7788 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL single_rsp: got rspv=%b data=%h err=%b want 10 1122334455667788 0", rsp_valid, rsp_data, rsp_err);
    end
    req_valid = 2'b00; RVALID = 1'b0; RLAST = 1'b0;
    tick();
    n_checks++;
    if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_end: got rspv=%b busy=%b want 00 0", rsp_valid, busy);
    end
  endtask

  task automatic test_contention();
    logic [N_REQ-1:0] exp_g [5];
    logic [ADDR_W-1:0] exp_a;
`ifdef MEM_ARB_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
`endif
    ARREADY = 1'b1; RVALID = 1'b0; RLAST = 1'b0;
    req_addr[0 +: ADDR_W]      = 32'h0000_1000;
    req_addr[ADDR_W +: ADDR_W] = 32'h0000_2000;
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      int c;
      c = 0;
      while (ARVALID !== 1'b1 && c < 10) begin tick(); c++; end
      exp_a = exp_g[k][0] ? 32'h0000_1000 : 32'h0000_2000;
      n_checks++;
      if (ARVALID !== 1'b1 || ARADDR !== exp_a) begin
        n_fail++; $display("FAIL contend_ar%0d: got arv=%b addr=%h want 1 %h", k, ARVALID, ARADDR, exp_a);
      end
      RVALID = 1'b1; RLAST = 1'b1; RDATA = 64'(k + 1);
      c = 0;
      while (rsp_valid === 2'b00 && c < 10) begin tick(); c++; end
      n_checks++;
      if (rsp_valid !== exp_g[k] || rsp_data !== 64'(k + 1)) begin
        n_fail++; $display("FAIL contend_rsp%0d: got rspv=%b data=%h want %b %h", k, rsp_valid, rsp_data, exp_g[k], 64'(k + 1));
      end
      RVALID = 1'b0; RLAST = 1'b0;
      if (k == 3) req_valid = 2'b10;
      if (k == 4) req_valid = 2'b00;
    end
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL contend_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_backpressure();
    ARREADY = 1'b0;
    req_addr[0 +: ADDR_W] = 32'h0000_1230;
    req_valid = 2'b01;
    tick();
    n_checks++;
    if (ARVALID !== 1'b1 || ARADDR !== 32'h0000_1230) begin
      n_fail++; $display("FAIL bp_ar: got arv=%b addr=%h want 1 00001230", ARVALID, ARADDR);
    end
    req_addr[0 +: ADDR_W] = 32'h0000_DEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (ARVALID !== 1'b1 || ARADDR !== 32'h0000_1230) begin
        n_fail++; $display("FAIL bp_ar_hold%0d: got arv=%b addr=%h want 1 00001230", i, ARVALID, ARADDR);
      end
    end
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    n_checks++;
    if ({ARVALID, RREADY} !== 2'b01) begin
      n_fail++; $display("FAIL bp_hs: got arv=%b rready=%b want 0 1", ARVALID, RREADY);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (rsp_valid !== 2'b00 || RREADY !== 1'b1 || busy !== 1'b1) begin
        n_fail++; $display("FAIL bp_wait%0d: got rspv=%b rready=%b busy=%b want 00 1 1", i, rsp_valid, RREADY, busy);
      end
    end
    RVALID = 1'b1; RLAST = 1'b1; RDATA = 64'h0000_0000_0000_CAFE;
    tick();
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== 64'h0000_0000_0000_CAFE) begin
      n_fail++; $display("FAIL bp_rsp: got rspv=%b data=%h want 01 cafe", rsp_valid, rsp_data);
    end
    RVALID = 1'b0; RLAST = 1'b0; req_valid = 2'b00;
    tick();
    n_checks++;
    if (rsp_valid !== 2'b00 || RREADY !== 1'b0) begin
      n_fail++; $display("FAIL bp_pulse: got rspv=%b rready=%b want 00 0", rsp_valid, RREADY);
    end
  endtask

  task automatic test_error_burst();
    ARREADY = 1'b1;
    req_addr[ADDR_W +: ADDR_W] = 32'h0000_4000;
    req_valid = 2'b10;
    tick();
    tick();
    RVALID = 1'b1; RLAST = 1'b0; RRESP = 2'b10; RDATA = 64'h0000_0000_0000_DEAD;
    tick();
    n_checks++;
    if (rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL err_beat1: got rspv=%b want 00", rsp_valid);
    end
    RLAST = 1'b1; RRESP = 2'b00; RDATA = 64'h0000_0000_0000_00AB;
    tick();
    n_checks++;
    if (rsp_valid !== 2'b10 || rsp_data !== 64'h0000_0000_0000_00AB || rsp_err !== 1'b1) begin
      n_fail++; $display("FAIL err_rsp: got rspv=%b data=%h err=%b want 10 ab 1", rsp_valid, rsp_data, rsp_err);
    end
    RVALID = 1'b0; RLAST = 1'b0; req_valid = 2'b00;
    tick(); tick();
    n_checks++;
    if (rsp_data !== 64'h0000_0000_0000_00AB || rsp_err !== 1'b1) begin
      n_fail++; $display("FAIL err_hold: got data=%h err=%b want ab 1", rsp_data, rsp_err);
    end
  endtask

  task automatic test_reset_in_data();
    ARREADY = 1'b1;
    req_addr[0 +: ADDR_W] = 32'h0000_5000;
    req_valid = 2'b01;
    tick();
    tick();
    n_checks++;
    if (RREADY !== 1'b1) begin
      n_fail++; $display("FAIL rst_in_data: got rready=%b want 1", RREADY);
    end
    ARESETn = 1'b0; req_valid = 2'b00;
    #1;
    n_checks++;
    if ({ARVALID, RREADY, busy, rsp_err} !== 4'b0000 || ARADDR !== 32'h0 ||
        rsp_data !== 64'h0 || rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL rst_async: got arv/rr/busy/err=%b addr=%h data=%h rspv=%b want zeros",
                         {ARVALID, RREADY, busy, rsp_err}, ARADDR, rsp_data, rsp_valid);
    end
    RVALID = 1'b1; RLAST = 1'b1; RDATA = 64'h0000_0000_0000_0BAD;
    tick();
    ARESETn = 1'b1;
    tick(); tick();
    n_checks++;
    if (rsp_valid !== 2'b00 || RREADY !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_stale: got rspv=%b rready=%b busy=%b want 00 0 0", rsp_valid, RREADY, busy);
    end
    RVALID = 1'b0; RLAST = 1'b0;
    req_addr[0 +: ADDR_W] = 32'h0000_6000;
    req_valid = 2'b01;
    tick();
    n_checks++;
    if (ARVALID !== 1'b1 || ARADDR !== 32'h0000_6000) begin
      n_fail++; $display("FAIL rst_new_ar: got arv=%b addr=%h want 1 00006000", ARVALID, ARADDR);
    end
    RVALID = 1'b1; RLAST = 1'b1; RDATA = 64'h0000_0000_0000_0077;
    tick(); tick();
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_data !== 64'h0000_0000_0000_0077 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL rst_new_rsp: got rspv=%b data=%h err=%b want 01 77 0", rsp_valid, rsp_data, rsp_err);
    end
    RVALID = 1'b0; RLAST = 1'b0; req_valid = 2'b00;
    tick();
  endtask

  task automatic test_withdrawal();
    ARREADY = 1'b0;
    req_addr[ADDR_W +: ADDR_W] = 32'h8000_0040;
    req_valid = 2'b10;
    tick();
    n_checks++;
    if (ARVALID !== 1'b1 || ARADDR !== 32'h8000_0040) begin
      n_fail++; $display("FAIL wd_ar: got arv=%b addr=%h want 1 80000040", ARVALID, ARADDR);
    end
    req_valid = 2'b00;
    req_addr[ADDR_W +: ADDR_W] = 32'h9999_0000;
    tick();
    n_checks++;
    if (ARVALID !== 1'b1 || ARADDR !== 32'h8000_0040) begin
      n_fail++; $display("FAIL wd_hold: got arv=%b addr=%h want 1 80000040", ARVALID, ARADDR);
    end
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    RVALID = 1'b1; RLAST = 1'b1; RDATA = 64'h0000_0000_0000_0066;
    tick();
    n_checks++;
    if (rsp_valid !== 2'b10 || rsp_data !== 64'h0000_0000_0000_0066) begin
      n_fail++; $display("FAIL wd_rsp: got rspv=%b data=%h want 10 66", rsp_valid, rsp_data);
    end
    RVALID = 1'b0; RLAST = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || ARVALID !== 1'b0 || rsp_valid !== 2'b00) begin
      n_fail++; $display("FAIL wd_idle: got busy=%b arv=%b rspv=%b want 0 0 00", busy, ARVALID, rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_error_burst();
    test_reset_in_data();
    test_withdrawal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
